// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a shared
// ready-handshake memory port, with a wait timeout, a sticky fault and a retired-instruction count.
//
// state  | meaning
// START  | one idle cycle after reset
// FETCH  | instruction request held until mem_ready
// DECODE | opcode legality check, opcode captured into op_q
// EXEC   | ALU operation; branches retire here
// MEM    | data load/store held until mem_ready; stores retire here
// WB     | register write-back and PC commit
// FAULT  | absorbing error state, left only through reset
module multicycle_controller #(
   parameter int TIMEOUT_W     = 8,
   parameter int CNT_W         = 32,
   parameter bit SUPPORT_UPPER = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [6:0]       Opcode,
   input  logic             mem_ready,
   output logic             InstrReq,
   output logic             IRWrite,
   output logic             ALUSrcA,
   output logic             ALUSrc,
   output logic [1:0]       ALUOp,
   output logic [1:0]       MemtoReg,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             RegWrite,
   output logic             Branch,
   output logic             Jump,
   output logic             JumpReg,
   output logic             PCWrite,
   output logic             Fault,
   output logic [1:0]       FaultCode,
   output logic [CNT_W-1:0] InstRet,
   output logic [2:0]       State
);

   typedef enum logic [2:0] {
      S_START  = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_FAULT  = 3'd7
   } state_t;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [1:0] FC_NONE    = 2'b00;
   localparam logic [1:0] FC_ILLEGAL = 2'b01;
   localparam logic [1:0] FC_FETCH   = 2'b10;
   localparam logic [1:0] FC_DATA    = 2'b11;

   state_t               state_q, state_d;
   logic [6:0]           op_q, op_d;
   logic [TIMEOUT_W-1:0] wait_q, wait_d, wait_inc;
   logic [CNT_W-1:0]     instret_q;
   logic [1:0]           fcode_q, fcode_d;
   logic                 legal, timeout;
   logic [1:0]           alu_op_dec, m2r_dec;
   logic                 alu_src_dec, alu_srca_dec;

   always_comb begin
      case (Opcode)
         OP_R, OP_LW, OP_SW, OP_BR, OP_IMM, OP_JAL, OP_JALR: legal = 1'b1;
         OP_LUI, OP_AUIPC:                                   legal = SUPPORT_UPPER;
         default:                                            legal = 1'b0;
      endcase
   end

   always_comb begin
      alu_op_dec   = 2'b10;
      alu_src_dec  = 1'b0;
      alu_srca_dec = 1'b0;
      m2r_dec      = 2'b00;
      case (op_q)
         OP_LW:            begin alu_op_dec = 2'b00; alu_src_dec = 1'b1; m2r_dec = 2'b01; end
         OP_SW:            begin alu_op_dec = 2'b00; alu_src_dec = 1'b1; end
         OP_BR:            alu_op_dec = 2'b01;
         OP_IMM:           alu_src_dec = 1'b1;
         OP_JAL, OP_JALR:  begin alu_op_dec = 2'b11; alu_src_dec = 1'b1; m2r_dec = 2'b10; end
         OP_LUI:           begin alu_op_dec = 2'b00; alu_src_dec = 1'b1; m2r_dec = 2'b11; end
         OP_AUIPC:         begin alu_op_dec = 2'b00; alu_src_dec = 1'b1; alu_srca_dec = 1'b1; end
         default:          ;
      endcase
   end

   // Saturating increment; the timeout fires on the wait cycle that makes the counter all-ones.
   assign wait_inc = (&wait_q) ? wait_q : wait_q + 1'b1;
   assign timeout  = &wait_inc;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      fcode_d  = fcode_q;
      InstrReq = 1'b0;
      IRWrite  = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrc   = 1'b0;
      ALUOp    = 2'b00;
      MemtoReg = 2'b00;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      Branch   = 1'b0;
      Jump     = 1'b0;
      JumpReg  = 1'b0;
      PCWrite  = 1'b0;
      case (state_q)
         S_START: state_d = S_FETCH;
         S_FETCH: begin
            InstrReq = 1'b1;
            if (mem_ready) begin
               IRWrite = 1'b1;
               state_d = S_DECODE;
            end else if (timeout) begin
               state_d = S_FAULT;
               fcode_d = FC_FETCH;
            end
         end
         S_DECODE: begin
            if (legal) begin
               op_d    = Opcode;
               state_d = S_EXEC;
            end else begin
               state_d = S_FAULT;
               fcode_d = FC_ILLEGAL;
            end
         end
         S_EXEC: begin
            ALUSrcA = alu_srca_dec;
            ALUSrc  = alu_src_dec;
            ALUOp   = alu_op_dec;
            if (op_q == OP_BR) begin
               Branch  = 1'b1;
               PCWrite = 1'b1;
               state_d = S_FETCH;
            end else if (op_q == OP_LW || op_q == OP_SW) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            ALUSrcA  = alu_srca_dec;
            ALUSrc   = alu_src_dec;
            ALUOp    = alu_op_dec;
            MemRead  = (op_q == OP_LW);
            MemWrite = (op_q == OP_SW);
            if (mem_ready) begin
               if (op_q == OP_LW) begin
                  state_d = S_WB;
               end else begin
                  PCWrite = 1'b1;
                  state_d = S_FETCH;
               end
            end else if (timeout) begin
               state_d = S_FAULT;
               fcode_d = FC_DATA;
            end
         end
         S_WB: begin
            ALUSrcA  = alu_srca_dec;
            ALUSrc   = alu_src_dec;
            ALUOp    = alu_op_dec;
            MemtoReg = m2r_dec;
            RegWrite = 1'b1;
            PCWrite  = 1'b1;
            Jump     = (op_q == OP_JAL);
            JumpReg  = (op_q == OP_JALR);
            state_d  = S_FETCH;
         end
         S_FAULT: ;
         default: state_d = S_START;
      endcase
   end

   always_comb begin
      if (state_d != state_q)
         wait_d = '0;
      else if (state_q == S_FETCH || state_q == S_MEM)
         wait_d = wait_inc;
      else
         wait_d = wait_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_START;
         op_q      <= '0;
         wait_q    <= '0;
         instret_q <= '0;
         fcode_q   <= FC_NONE;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         wait_q    <= wait_d;
         fcode_q   <= fcode_d;
         if (PCWrite)
            instret_q <= instret_q + 1'b1;
      end
   end

   assign Fault     = (state_q == S_FAULT);
   assign FaultCode = fcode_q;
   assign InstRet   = instret_q;
   assign State     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: a per-instruction table model predicts
// latency, handshake counts and retire-cycle controls; a negedge monitor checks them on each PCWrite.
module tb_multicycle_controller;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   logic clk, reset_n, mem_ready;
   logic [6:0] Opcode;
   logic InstrReq, IRWrite, ALUSrcA, ALUSrc, MemRead, MemWrite, RegWrite, Branch, Jump, JumpReg, PCWrite, Fault;
   logic [1:0] ALUOp, MemtoReg, FaultCode;
   logic [31:0] InstRet;
   logic [2:0] State;
   logic InstrReq0, IRWrite0, ALUSrcA0, ALUSrc0, MemRead0, MemWrite0, RegWrite0, Branch0, Jump0, JumpReg0, PCWrite0, Fault0;
   logic [1:0] ALUOp0, MemtoReg0, FaultCode0;
   logic [31:0] InstRet0;
   logic [2:0] State0;

   multicycle_controller #(.TIMEOUT_W(4), .CNT_W(32), .SUPPORT_UPPER(1'b1)) u_dut (
      .clk(clk), .reset_n(reset_n), .Opcode(Opcode), .mem_ready(mem_ready),
      .InstrReq(InstrReq), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
      .MemtoReg(MemtoReg), .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
      .Branch(Branch), .Jump(Jump), .JumpReg(JumpReg), .PCWrite(PCWrite), .Fault(Fault),
      .FaultCode(FaultCode), .InstRet(InstRet), .State(State));

   multicycle_controller #(.TIMEOUT_W(4), .CNT_W(32), .SUPPORT_UPPER(1'b0)) u_dut_noupper (
      .clk(clk), .reset_n(reset_n), .Opcode(Opcode), .mem_ready(mem_ready),
      .InstrReq(InstrReq0), .IRWrite(IRWrite0), .ALUSrcA(ALUSrcA0), .ALUSrc(ALUSrc0), .ALUOp(ALUOp0),
      .MemtoReg(MemtoReg0), .MemRead(MemRead0), .MemWrite(MemWrite0), .RegWrite(RegWrite0),
      .Branch(Branch0), .Jump(Jump0), .JumpReg(JumpReg0), .PCWrite(PCWrite0), .Fault(Fault0),
      .FaultCode(FaultCode0), .InstRet(InstRet0), .State(State0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] op;
      int lat, ireq, mrd, mwr, regw;
      logic br, jmp, jr, asrc, asrca;
      logic [1:0] m2r, aluop;
      int iret;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int errors = 0;
   int retired, pcw0, pcw0_base;
   bit first;
   int m_cyc, m_ireq, m_irw, m_mrd, m_mwr, m_regw;
   logic [6:0] ops [9] = '{OP_R, OP_LW, OP_SW, OP_BR, OP_IMM, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference model: timing and controls of one instruction, straight from the opcode table.
   function automatic exp_t model(input logic [6:0] op, input int fw, input int mw, input bit frst, input int iret);
      exp_t e;
      e.op = op; e.ireq = fw + 1; e.mrd = 0; e.mwr = 0; e.regw = 1;
      e.br = 0; e.jmp = 0; e.jr = 0; e.asrc = 0; e.asrca = 0;
      e.m2r = 2'b00; e.aluop = 2'b10; e.iret = iret;
      e.lat = 4 + fw + (frst ? 1 : 0);
      case (op)
         OP_IMM:   e.asrc = 1;
         OP_LW:    begin e.aluop = 2'b00; e.asrc = 1; e.m2r = 2'b01; e.mrd = mw + 1; e.lat += 1 + mw; end
         OP_SW:    begin e.aluop = 2'b00; e.asrc = 1; e.mwr = mw + 1; e.regw = 0; e.lat += mw; end
         OP_BR:    begin e.aluop = 2'b01; e.br = 1; e.regw = 0; e.lat -= 1; end
         OP_JAL:   begin e.aluop = 2'b11; e.asrc = 1; e.m2r = 2'b10; e.jmp = 1; end
         OP_JALR:  begin e.aluop = 2'b11; e.asrc = 1; e.m2r = 2'b10; e.jr = 1; end
         OP_LUI:   begin e.aluop = 2'b00; e.asrc = 1; e.m2r = 2'b11; end
         OP_AUIPC: begin e.aluop = 2'b00; e.asrc = 1; e.asrca = 1; end
         default:  ;
      endcase
      return e;
   endfunction

   always @(negedge clk) begin
      if (PCWrite0) pcw0++;
      if (!reset_n) begin
         m_cyc = 0; m_ireq = 0; m_irw = 0; m_mrd = 0; m_mwr = 0; m_regw = 0;
      end else begin
         m_cyc++;
         if (InstrReq) m_ireq++;
         if (IRWrite)  m_irw++;
         if (MemRead)  m_mrd++;
         if (MemWrite) m_mwr++;
         if (RegWrite) m_regw++;
         chk("req_exclusive", ((InstrReq && (MemRead || MemWrite)) || (MemRead && MemWrite)) ? 1 : 0, 0);
         if (PCWrite) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_retire", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk($sformatf("latency op=%b", e.op), m_cyc, e.lat);
               chk("instrreq_cycles", m_ireq, e.ireq);
               chk("irwrite_pulses", m_irw, 1);
               chk("memread_cycles", m_mrd, e.mrd);
               chk("memwrite_cycles", m_mwr, e.mwr);
               chk("regwrite_pulses", m_regw, e.regw);
               chk("branch", int'(Branch), int'(e.br));
               chk("jump", int'(Jump), int'(e.jmp));
               chk("jumpreg", int'(JumpReg), int'(e.jr));
               chk("aluop", int'(ALUOp), int'(e.aluop));
               chk("alusrc", int'(ALUSrc), int'(e.asrc));
               chk("alusrca", int'(ALUSrcA), int'(e.asrca));
               chk("instret", int'(InstRet), e.iret);
               if (e.regw != 0) chk("memtoreg", int'(MemtoReg), int'(e.m2r));
            end
            m_cyc = 0; m_ireq = 0; m_irw = 0; m_mrd = 0; m_mwr = 0; m_regw = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic noise();
      mem_ready = 1'($urandom_range(0, 1));
      Opcode    = 7'($urandom);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      exp_q.delete();
      tick(); tick();
      reset_n = 1'b1;
      retired = 0;
      first   = 1'b1;
   endtask

   task automatic wait_fetch();
      int k = 0;
      while (!InstrReq && k < 8) begin noise(); tick(); k++; end
      chk("fetch_request", int'(InstrReq), 1);
   endtask

   // Memory/instruction-register stand-in for one instruction with given wait counts.
   task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
      exp_q.push_back(model(op, fw, mw, first, retired));
      retired++;
      first = 1'b0;
      wait_fetch();
      for (int w = 0; w <= fw; w++) begin mem_ready = (w == fw); Opcode = op; tick(); end
      Opcode = op; mem_ready = 1'($urandom_range(0, 1)); tick();
      noise(); tick();
      if (op == OP_LW || op == OP_SW) begin
         for (int w = 0; w <= mw; w++) begin mem_ready = (w == mw); Opcode = 7'($urandom); tick(); end
         if (op == OP_LW) begin noise(); tick(); end
      end else if (op != OP_BR) begin
         noise(); tick();
      end
   endtask

   task automatic go_to_mem(input logic [6:0] op);
      wait_fetch();
      mem_ready = 1'b1; Opcode = op; tick();
      tick();
      tick();
   endtask

   task automatic drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 40) begin noise(); tick(); k++; end
      chk("scoreboard_drained", exp_q.size(), 0);
   endtask

   initial begin
      int n;
      reset_n = 1'b0; mem_ready = 1'b0; Opcode = '0; pcw0 = 0;
      retired = 0; first = 1'b1;
      tick(); tick();
      chk("rst_state", int'(State), 0);
      chk("rst_fault", int'({Fault, FaultCode}), 0);
      chk("rst_instret", int'(InstRet), 0);
      chk("rst_strobes", int'({InstrReq, IRWrite, MemRead, MemWrite, RegWrite, Branch, Jump, JumpReg, PCWrite}), 0);
      reset_n = 1'b1;

      run_instr(OP_R, 0, 0);
      run_instr(OP_LW, 0, 3);
      run_instr(OP_BR, 0, 0);
      run_instr(OP_SW, 1, 2);
      run_instr(OP_JALR, 0, 0);
      run_instr(OP_LUI, 2, 0);
      run_instr(OP_AUIPC, 0, 0);
      run_instr(OP_JAL, 1, 0);
      run_instr(OP_IMM, 0, 0);
      for (int i = 0; i < 40; i++)
         run_instr(ops[$urandom_range(0, 8)], $urandom_range(0, 3), $urandom_range(0, 3));
      drain();
      tick();
      chk("instret_total", int'(InstRet), retired);
      chk("no_fault_main", int'(Fault), 0);

      // LUI: legal on the main instance, illegal when upper immediates are unsupported.
      do_reset();
      pcw0_base = pcw0;
      run_instr(OP_LUI, 0, 0);
      drain();
      chk("noupper_fault", int'(Fault0), 1);
      chk("noupper_code", int'(FaultCode0), 1);
      chk("noupper_state", int'(State0), 7);
      chk("noupper_instret", int'(InstRet0), 0);
      chk("noupper_pcwrite", pcw0 - pcw0_base, 0);

      wait_fetch();
      mem_ready = 1'b1; Opcode = 7'b1111111; tick();
      tick();
      chk("illegal_state", int'(State), 7);
      chk("illegal_code", int'(FaultCode), 1);
      chk("illegal_instret", int'(InstRet), 1);
      repeat (5) begin noise(); tick(); end
      chk("fault_absorbing", int'({Fault, State}), 'hF);
      chk("fault_strobes", int'({InstrReq, MemRead, MemWrite, RegWrite, PCWrite}), 0);

      // Fetch timeout: 15 wait cycles with TIMEOUT_W=4.
      do_reset();
      mem_ready = 1'b0;
      tick();
      n = 0;
      while (InstrReq && n < 40) begin n++; tick(); end
      chk("fetch_timeout_cycles", n, 15);
      chk("fetch_timeout_code", int'(FaultCode), 2);
      chk("fetch_timeout_state", int'(State), 7);
      mem_ready = 1'b1; repeat (4) tick();
      chk("fetch_timeout_sticky", int'(FaultCode), 2);
      do_reset();
      chk("restart_state", int'(State), 0);
      chk("restart_instret", int'(InstRet), 0);
      chk("restart_fault", int'(Fault), 0);

      // Data timeout on a store.
      go_to_mem(OP_SW);
      mem_ready = 1'b0;
      n = 0;
      while (MemWrite && n < 40) begin n++; tick(); end
      chk("data_timeout_cycles", n, 15);
      chk("data_timeout_code", int'(FaultCode), 3);
      chk("data_timeout_instret", int'(InstRet), 0);

      // Reset asserted while a store waits in MEM.
      do_reset();
      go_to_mem(OP_SW);
      mem_ready = 1'b0; tick();
      chk("sw_in_mem", int'(MemWrite), 1);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_memwrite", int'(MemWrite), 0);
      chk("abort_pcwrite", int'(PCWrite), 0);
      chk("abort_state", int'(State), 0);
      tick();
      reset_n = 1'b1;
      exp_q.delete(); retired = 0; first = 1'b1;
      chk("abort_release_state", int'(State), 0);
      run_instr(OP_R, 0, 0);
      drain();
      tick();
      chk("abort_restart_instret", int'(InstRet), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
